// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, flag bit indices, divider constants.
// ALU_DIV_RADIX4_EN selects a 2-bit-per-cycle divider (DIV_STEPS = 4).
package alu_pkg;

  typedef enum logic [3:0] {
    ALUOP_ADD = 4'd0,
    ALUOP_SUB = 4'd1,
    ALUOP_AND = 4'd2,
    ALUOP_OR  = 4'd3,
    ALUOP_XOR = 4'd4,
    ALUOP_SHL = 4'd5,
    ALUOP_SHR = 4'd6,
    ALUOP_DIV = 4'd7
  } aluop_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_S = 3;

`ifdef ALU_DIV_RADIX4_EN
  localparam int unsigned DIV_STEPS = 4;
`else
  localparam int unsigned DIV_STEPS = 8;
`endif
  localparam int unsigned DIV_CNT_W = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic v, input logic s);
    logic [3:0] f;
    f         = 4'h0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_S] = s;
    return f;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module alu_div_step (
  input  logic [8:0] rem_i,
  input  logic       bit_i,
  input  logic [7:0] div_i,
  output logic [7:0] rem_o,
  output logic       quo_o
);

  logic [9:0] trial_s;

  always_comb begin
    trial_s = {rem_i, bit_i} - {2'b00, div_i};
    // With rem_i < div_i the non-negative trial always fits in 8 bits.
    quo_o = (trial_s[9:8] == 2'b00);
    if (quo_o) begin
      rem_o = trial_s[7:0];
    end else begin
      rem_o = {rem_i[6:0], bit_i};
    end
  end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned 16/8 restoring divider with ALU-compatible result/flags.
// ALU_DIV_RADIX4_EN cascades two steps per cycle (4 RUN cycles instead of 8).
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int unsigned SHORTCUT_P = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] R,
  output logic [3:0]  flags
);

  localparam bit SHORTCUT_EN = (SHORTCUT_P != 0);

  div_state_e           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          r_q, r_d;
  logic [3:0]           flags_q, flags_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]           prem_q, prem_d;
  logic [7:0]           quo_q, quo_d;
  logic [15:0]          a_q, a_d;
  logic [7:0]           b_q, b_d;
  logic                 exc_q, exc_d;
  logic                 dbz_q, dbz_d;

  logic                 dbz_s, exc_s;
  logic [7:0]           step_rem_s;
  logic [7:0]           step_quo_s;
  logic                 q0_s;
  logic [7:0]           rem0_s;

  alu_div_step u_step0 (
    .rem_i (prem_q),
    .bit_i (quo_q[7]),
    .div_i (b_q),
    .rem_o (rem0_s),
    .quo_o (q0_s)
  );

`ifdef ALU_DIV_RADIX4_EN
  logic       q1_s;
  logic [7:0] rem1_s;

  alu_div_step u_step1 (
    .rem_i ({1'b0, rem0_s}),
    .bit_i (quo_q[6]),
    .div_i (b_q),
    .rem_o (rem1_s),
    .quo_o (q1_s)
  );

  assign step_rem_s = rem1_s;
  assign step_quo_s = {quo_q[5:0], q0_s, q1_s};
`else
  assign step_rem_s = rem0_s;
  assign step_quo_s = {quo_q[6:0], q0_s};
`endif

  assign dbz_s = (B == 8'h00);
  assign exc_s = dbz_s || (A[15:8] >= B);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    a_d     = a_q;
    b_d     = b_q;
    exc_d   = exc_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          exc_d  = exc_s;
          dbz_d  = dbz_s;
          prem_d = {1'b0, A[15:8]};
          quo_d  = A[7:0];
          cnt_d  = DIV_CNT_W'(DIV_STEPS - 1);
          busy_d = 1'b1;
          if (exc_s && SHORTCUT_EN) begin
            state_d = DIV_DONE;
            done_d  = 1'b1;
            r_d     = A;
            flags_d = pack_flags(1'b0, 1'b0, 1'b1, dbz_s ? 1'b1 : A[7]);
          end else begin
            state_d = DIV_RUN;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      DIV_RUN: begin
        prem_d = {1'b0, step_rem_s};
        quo_d  = step_quo_s;
        cnt_d  = cnt_q - DIV_CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
          // Fixed-timing mode: exceptions ran the full latency, result forced here.
          if (exc_q) begin
            r_d     = a_q;
            flags_d = pack_flags(1'b0, 1'b0, 1'b1, dbz_q ? 1'b1 : a_q[7]);
          end else begin
            r_d     = {step_rem_s, step_quo_s};
            flags_d = pack_flags(({step_rem_s, step_quo_s} == 16'h0000),
                                 1'b0, 1'b0, step_quo_s[7]);
          end
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= 16'h0000;
      flags_q <= 4'h0;
      cnt_q   <= '0;
      prem_q  <= 9'h000;
      quo_q   <= 8'h00;
      a_q     <= 16'h0000;
      b_q     <= 8'h00;
      exc_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exc_q   <= exc_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign R     = r_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq (shortcut and fixed-timing instances).
module tb_alu_div_seq;

`ifdef ALU_DIV_RADIX4_EN
  localparam int LAT_N = 5;
`else
  localparam int LAT_N = 9;
`endif

  logic        clk;
  logic        reset_n;
  logic        start0, start1;
  logic [15:0] A;
  logic [7:0]  B;
  logic        busy0, done0, busy1, done1;
  logic [15:0] r0, r1;
  logic [3:0]  flags0, flags1;

  int n_checks;
  int n_errors;

  alu_div_seq #(.SHORTCUT_P(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .A(A), .B(B),
    .busy(busy0), .done(done0), .R(r0), .flags(flags0)
  );

  alu_div_seq #(.SHORTCUT_P(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .A(A), .B(B),
    .busy(busy1), .done(done1), .R(r1), .flags(flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic sel_done(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  function automatic logic [15:0] sel_r(input int inst);
    return (inst == 0) ? r0 : r1;
  endfunction

  function automatic logic [3:0] sel_flags(input int inst);
    return (inst == 0) ? flags0 : flags1;
  endfunction

  // Issue one operation, then check latency, busy window, result, flags and idle return.
  task automatic do_op(input string tag, input int inst, input logic [15:0] a,
                       input logic [7:0] b, input int exp_lat,
                       input logic [15:0] exp_r, input logic [3:0] exp_f);
    int done_cyc;
    logic busy_ok;
    done_cyc = 0;
    busy_ok  = 1'b1;
    @(negedge clk);
    A = a;
    B = b;
    if (inst == 0) start0 = 1'b1;
    else           start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    A = ~a;
    B = ~b;
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (!sel_busy(inst)) busy_ok = 1'b0;
      if (sel_done(inst)) done_cyc = k;
    end
    check_eq({tag, "_lat"}, done_cyc, exp_lat);
    check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_r"}, {16'd0, sel_r(inst)}, {16'd0, exp_r});
    check_eq({tag, "_flags"}, {28'd0, sel_flags(inst)}, {28'd0, exp_f});
    @(negedge clk);
    check_eq({tag, "_idle"}, {30'd0, sel_busy(inst), sel_done(inst)}, 32'd0);
    check_eq({tag, "_hold"}, {16'd0, sel_r(inst)}, {16'd0, exp_r});
  endtask

  initial begin
    int dones;
    int done_at;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    A        = 16'h0000;
    B        = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_outs0", {10'd0, busy0, done0, flags0, r0}, 32'd0);
    check_eq("rst_outs1", {10'd0, busy1, done1, flags1, r1}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op("norm_1234",  0, 16'h1234, 8'h56, LAT_N, 16'h1036, 4'b0000);
    do_op("dbz_sc",     0, 16'h00FF, 8'h00, 1,     16'h00FF, 4'b1100);
    do_op("ovf_sc",     0, 16'h8000, 8'h40, 1,     16'h8000, 4'b0100);
    do_op("norm_7f80",  0, 16'h7F80, 8'h80, LAT_N, 16'h00FF, 4'b1000);
    do_op("zero",       0, 16'h0000, 8'h05, LAT_N, 16'h0000, 4'b0001);
    do_op("dbz_fixed",  1, 16'h00FF, 8'h00, LAT_N, 16'h00FF, 4'b1100);
    do_op("ovf_fixed",  1, 16'h8080, 8'h40, LAT_N, 16'h8080, 4'b1100);
    do_op("norm_fixed", 1, 16'h1234, 8'h56, LAT_N, 16'h1036, 4'b0000);
    do_op("eq_ovf_sc",  0, 16'h0512, 8'h05, 1,     16'h0512, 4'b0100);

    // start held high with changing operands: only the first accept counts.
    dones   = 0;
    done_at = 0;
    @(negedge clk);
    A = 16'h1234;
    B = 8'h56;
    start0 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done0) begin
        dones++;
        if (done_at == 0) done_at = k;
      end
      if (k <= LAT_N) begin
        A = 16'h0101 * k[15:0];
        B = 8'h03 + k[7:0];
      end else begin
        start0 = 1'b0;
      end
    end
    check_eq("stream_dones", dones, 1);
    check_eq("stream_lat", done_at, LAT_N);
    check_eq("stream_r", {16'd0, r0}, {16'd0, 16'h1036});
    check_eq("stream_flags", {28'd0, flags0}, 32'd0);

    // Reset in the middle of a run.
    @(negedge clk);
    A = 16'h7F80;
    B = 8'h80;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_busy", {31'd0, busy0}, 32'd1);
    check_eq("mid_hold_r", {16'd0, r0}, {16'd0, 16'h1036});
    reset_n = 1'b0;
    #1;
    check_eq("abort_outs", {10'd0, busy0, done0, flags0, r0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done0 || busy0) dones++;
    end
    check_eq("no_stale_done", dones, 0);
    do_op("after_rst",  0, 16'h7F80, 8'h80, LAT_N, 16'h00FF, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle unsigned 16/8 divider that sits beside the combinational ALU in the CPU execute stage.
- The control unit issues DIV to this block instead of the ALU and stalls on busy. On done, it muxes this block's result and flags onto the same R/flags writeback path the ALU drives.
- Result packing and flag semantics match the ALU so that writeback logic is shared.

Parameters:
- SHORTCUT_P, 1: 1 = divide-by-zero and overflow complete in 1 cycle; 0 = they still occupy the full iteration latency (fixed-timing mode).

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only when busy=0
- A  input  16  dividend
- B  input  8  divisor
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  single-cycle pulse; R/flags valid this cycle and held afterwards
- R  output  16  {remainder[7:0], quotient[7:0]}
- flags  output  4  bit order Z=0, C=1, V=2, S=3 (shared package indices)

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release): state=IDLE, busy=0, done=0, R=16'h0000, flags=4'h0, iteration counter=0, internal partial remainder/quotient registers=0.
- Handshake:
  - start is accepted on a rising edge where state=IDLE.
  - start while busy=1, or in the DONE cycle, is ignored (no queueing).
  - A and B are captured at acceptance; later changes to them have no effect.
- States: IDLE, RUN, DONE.
  - IDLE→RUN on accepted start with B≠0 and A[15:8]<B.
  - IDLE→DONE on accepted start with B==0 or A[15:8]≥B, when SHORTCUT_P=1. With SHORTCUT_P=0 it goes to RUN, and the exception result is forced at exit.
  - RUN→DONE after the 8th step (counter 7→0).
  - DONE→IDLE unconditionally after 1 cycle.
- Latency, with the accept edge as cycle 0:
  - Normal: busy=1 in cycles 1-9; done=1 in cycle 9.
  - Shortcut: busy=1 and done=1 in cycle 1.
- Restoring algorithm, one quotient bit per cycle, MSB first:
  - Partial remainder is 9 bits wide, initialised to A[15:8].
  - Dividend low byte is shifted in one bit per step.
  - trial = {prem, next_bit} − {1'b0, B}. If the trial is non-negative, the remainder becomes trial[7:0] and the quotient bit is 1; otherwise the remainder is unchanged and the quotient bit is 0.
  - Because A[15:8]<B is guaranteed, the quotient fits in 8 bits.
- Normal result: R={rem, quo}; Z=(R==16'h0000); C=0; V=0; S=quo[7].
- Divide-by-zero (B==0): R=A; Z=0; C=0; V=1; S=1.
- Overflow (B≠0, A[15:8]≥B): R=A; Z=0; C=0; V=1; S=A[7].
- R and flags update only in the DONE cycle and hold until the next DONE. This holds even when a new operation is in RUN.
- Reset mid-operation: returns immediately to reset values. done must not pulse for the aborted operation.

Optional Feature:
- Macro: ALU_DIV_RADIX4_EN.
- Defined: the divider retires 2 quotient bits per cycle (two cascaded restoring steps). It uses 4 RUN cycles, so the normal done comes in cycle 5 and busy=1 in cycles 1-5. Results, flags and the shortcut paths are identical to the undefined case.
- Undefined: 1 bit per cycle, with 8 RUN cycles as specified above.

Decomposition:
- Shared package (alu_pkg) holds:
  - the ALUOP enum, including the DIV code the control unit uses to route here;
  - the flag index constants Z/C/V/S;
  - DIV_STEPS (8, or 4 with the macro).
  - The ALU and this block both import it.
- Sub-module alu_div_step: purely combinational single restoring step (9-bit remainder in, next dividend bit, 8-bit divisor → 8-bit remainder out, quotient bit). It is instantiated once, or twice in cascade under ALU_DIV_RADIX4_EN.

Test Plan:
- A=16'h1234, B=8'h56, start → done in cycle 9 (cycle 5 with the macro), R=16'h1036, flags Z=0 C=0 V=0 S=0; busy high in cycles 1-9.
- A=16'h00FF, B=8'h00 → done in cycle 1 (SHORTCUT_P=1), R=16'h00FF, V=1 S=1 Z=0 C=0. Repeat with SHORTCUT_P=0 → done in cycle 9 with identical R and flags.
- A=16'h8000, B=8'h40 (overflow) → R=16'h8000, V=1, S=0, Z=0; then A=16'h7F80, B=8'h80 → normal, R=16'h00FF, S=1, V=0.
- A=16'h0000, B=8'h05 → done in cycle 9, R=16'h0000, Z=1, others 0.
- Start asserted every cycle with changing A/B during RUN → only the first operation runs; R reflects the first operands; exactly one done pulse per accepted start.
- reset_n deasserted low in cycle 4 of RUN → busy=0, done=0, R=0, flags=0 immediately. After release, a new start completes normally with no stale done pulse.
